// File: rtl/branch_pred_pkg.sv
// Shared types for the dynamic branch predictor.
//   bp_ctr_t    : 2-bit saturating direction counter
//   btb_entry_t : one direct-mapped BTB entry (valid, tag, target, ctr)
package branch_pred_pkg;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SNT = 2'b00;  // strongly not taken
  localparam bp_ctr_t BP_WNT = 2'b01;  // weakly not taken
  localparam bp_ctr_t BP_WT  = 2'b10;  // weakly taken
  localparam bp_ctr_t BP_ST  = 2'b11;  // strongly taken

  // Width of pc[31:2]; the real tag is narrower and is zero-extended into this field.
  localparam int unsigned BP_TAG_MAX_W = 30;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [31:0]             target;
    bp_ctr_t                 ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_pred_sat_ctr2.sv
// Next-state function of a 2-bit saturating counter.
//   i_ctr : current counter value
//   i_inc : 1 = count up (taken), 0 = count down (not taken)
//   o_ctr : next counter value, saturating at BP_SNT and BP_ST
module branch_pred_sat_ctr2
  import branch_pred_pkg::*;
(
  input  bp_ctr_t i_ctr,
  input  logic    i_inc,
  output bp_ctr_t o_ctr
);

  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != BP_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != BP_SNT) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_pred.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit counter per entry.
//   CLK, nRST          : clock, asynchronous active-low reset
//   pc_if              : IF-stage PC to look up (combinational)
//   pred_hit/taken/target : lookup result for pc_if
//   upd_*              : resolved-branch report from EX/MEM
//   mispredict, correct_pc : flush request and redirect PC (combinational)
//   mispred_cnt        : running misprediction count
module branch_pred
  import branch_pred_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_if,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned INDEX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 30 - INDEX_W;

  btb_entry_t  r_btb [ENTRIES];
  logic [31:0] r_mispred_cnt;

  // Lookup path
  logic [INDEX_W-1:0]      w_idx;
  logic [BP_TAG_MAX_W-1:0] w_tag_if;
  btb_entry_t              w_rd;

  assign w_idx    = pc_if[INDEX_W+1:2];
  assign w_tag_if = BP_TAG_MAX_W'(pc_if[31:INDEX_W+2]);
  assign w_rd     = r_btb[w_idx];

  always_comb begin
    pred_hit    = w_rd.valid && (w_rd.tag == w_tag_if);
    pred_taken  = pred_hit && w_rd.ctr[1];
    pred_target = pred_hit ? w_rd.target : 32'd0;
  end

  // Resolution path
  always_comb begin
    mispredict = upd_en && ((upd_taken != upd_pred_taken) ||
                            (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
    correct_pc = upd_taken ? upd_target : upd_pc + 32'd4;
  end

  // Update path
  logic [INDEX_W-1:0]      w_uidx;
  logic [BP_TAG_MAX_W-1:0] w_tag_upd;
  btb_entry_t              w_ue;
  logic                    w_upd_hit;
  bp_ctr_t                 w_ctr_next;

  assign w_uidx    = upd_pc[INDEX_W+1:2];
  assign w_tag_upd = BP_TAG_MAX_W'(upd_pc[31:INDEX_W+2]);
  assign w_ue      = r_btb[w_uidx];
  assign w_upd_hit = w_ue.valid && (w_ue.tag == w_tag_upd);

  branch_pred_sat_ctr2 u_sat_ctr2 (
    .i_ctr (w_ue.ctr),
    .i_inc (upd_taken),
    .o_ctr (w_ctr_next)
  );

  // Byte-offset bits are never used for indexing or tagging.
  logic w_unused_bits;
  assign w_unused_bits = ^{pc_if[1:0], upd_pc[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: BP_WNT};
      end
    end else if (upd_en) begin
      if (w_upd_hit) begin
        r_btb[w_uidx].ctr <= w_ctr_next;
        if (upd_taken) r_btb[w_uidx].target <= upd_target;
      end else if (upd_taken) begin
        // Allocate on taken miss, evicting any aliasing occupant.
        r_btb[w_uidx] <= '{valid: 1'b1, tag: w_tag_upd, target: upd_target, ctr: BP_WT};
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_mispred_cnt <= 32'd0;
    end else if (mispredict) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign mispred_cnt = r_mispred_cnt;

  // TAG_W documents the real tag width; storage uses the zero-extended field.
  logic [TAG_W-1:0] w_unused_tag;
  assign w_unused_tag = upd_pc[31:INDEX_W+2];

endmodule

// File: tb/tb_branch_pred.sv
module tb_branch_pred;

  logic        CLK;
  logic        nRST;
  logic [31:0] pc_if;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] mispred_cnt;

  int n_total = 0;
  int n_bad   = 0;

  branch_pred #(.ENTRIES(16)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .pc_if           (pc_if),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_en          (upd_en),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .correct_pc      (correct_pc),
    .mispred_cnt     (mispred_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tk, input logic [31:0] tgt);
    pc_if = pc;
    #1;
    check_eq({tag, ".hit"}, 32'(pred_hit), 32'(hit));
    check_eq({tag, ".taken"}, 32'(pred_taken), 32'(tk));
    check_eq({tag, ".target"}, pred_target, tgt);
  endtask

  // Drive one resolved branch for a single cycle, checking the combinational outputs first.
  task automatic upd(input string tag, input logic [31:0] pc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic exp_mp, input logic [31:0] exp_cpc);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt;
    #1;
    check_eq({tag, ".mispredict"}, 32'(mispredict), 32'(exp_mp));
    check_eq({tag, ".correct_pc"}, correct_pc, exp_cpc);
    @(posedge CLK);
    #1;
    upd_en = 1'b0;
  endtask

  initial begin
    nRST = 1'b1; pc_if = 32'h40; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;

    // 1. Asynchronous reset mid-cycle
    #3 nRST = 1'b0;
    #1;
    look("rst", 32'h40, 1'b0, 1'b0, 32'h0);
    check_eq("rst.cnt", mispred_cnt, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // 2. Allocate on taken miss
    upd("alloc", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100);
    look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    check_eq("alloc.cnt", mispred_cnt, 32'd1);

    // 3. Saturation: 10 -> 11 (held), then down to 00 (held), then back up
    for (int i = 0; i < 3; i++)
      upd("inc", 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
    upd("dec1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44);
    look("ctr10", 32'h40, 1'b1, 1'b1, 32'h100);
    upd("dec2", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h44);
    look("ctr01", 32'h40, 1'b1, 1'b0, 32'h100);
    upd("dec3", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44);
    upd("dec4", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h44);
    // A held 00 needs two taken updates before predicting taken again
    upd("up1", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100);
    look("ctr00to01", 32'h40, 1'b1, 1'b0, 32'h100);
    upd("up2", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100);
    look("ctr10b", 32'h40, 1'b1, 1'b1, 32'h100);
    check_eq("sat.cnt", mispred_cnt, 32'd5);

    // 4. Aliasing: 0x80 shares index 0 and evicts 0x40
    upd("alias", 32'h80, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1, 32'h300);
    look("alias40", 32'h40, 1'b0, 1'b0, 32'h0);
    look("alias80", 32'h80, 1'b1, 1'b1, 32'h300);

    // 5. Target mismatch with correct direction
    upd("realloc", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h100);
    upd("tgtmis", 32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h200);
    look("tgtmis", 32'h40, 1'b1, 1'b1, 32'h200);
    check_eq("tgt.cnt", mispred_cnt, 32'd8);

    // 6. Same-cycle lookup and update at 0x44: old state before edge, new after
    upd("alloc44", 32'h44, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
    pc_if = 32'h44; upd_en = 1'b1; upd_pc = 32'h44; upd_taken = 1'b1;
    upd_target = 32'h600; upd_pred_taken = 1'b1; upd_pred_target = 32'h500;
    #1;
    check_eq("same.pre.target", pred_target, 32'h500);
    check_eq("same.mispredict", 32'(mispredict), 32'd1);
    @(posedge CLK);
    #1;
    check_eq("same.post.target", pred_target, 32'h600);
    check_eq("same.post.hit", 32'(pred_hit), 32'd1);
    upd_en = 1'b0;

    // Not-taken miss: no allocation, sequential correct_pc
    upd("ntmiss", 32'h1000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1004);
    look("ntmiss", 32'h1000, 1'b0, 1'b0, 32'h0);

    // correct_pc wraps at the top of the address space
    upd("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
    check_eq("wrap.cnt", mispred_cnt, 32'd11);

    // No flush when nothing is being reported
    upd_en = 1'b0; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    #1;
    check_eq("noen.mispredict", 32'(mispredict), 32'd0);
    @(posedge CLK);
    #1;
    check_eq("noen.cnt", mispred_cnt, 32'd11);

    // Reset mid-operation clears state without a clock edge
    #2 nRST = 1'b0;
    #1;
    look("rst2", 32'h44, 1'b0, 1'b0, 32'h0);
    check_eq("rst2.cnt", mispred_cnt, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
